// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Two-port arbiter in front of a single SRAM-like memory port using an
// addr_ok / data_ok handshake. Only one transaction is outstanding at any time.
// The winning request is copied into local registers when it is granted, so the
// memory side never sees requester inputs change while a transaction is running.
//
// Parameters
//   DATA_PRIO  1: data port wins when both ports request in the same cycle
//              0: round-robin, the port not granted last wins a tie
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   inst_req/wr/size/wstrb/addr/wdata  instruction-port request
//   inst_addr_ok/data_ok/rdata         instruction-port response
//   data_req/wr/size/wstrb/addr/wdata  data-port request
//   data_addr_ok/data_ok/rdata         data-port response
//   mem_req/wr/size/wstrb/addr/wdata   memory-side request (driven only in StReq)
//   mem_addr_ok/data_ok/rdata          memory-side response

module sram_arbiter #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Owner of the transaction in flight: 1 = data port, 0 = inst port.
    logic owner_q, owner_d;
    // Set when the most recent grant went to the inst port; only steers ties
    // when DATA_PRIO is 0. Cleared at reset so inst wins the first tie.
    logic last_inst_q, last_inst_d;

    // Latched request fields.
    logic        wr_q,    wr_d;
    logic [1:0]  size_q,  size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic any_req;
    logic grant_data;

    assign any_req = inst_req | data_req;

    // Arbitration decision, only consumed in StIdle.
    always_comb begin
        grant_data = 1'b0;
        if (DATA_PRIO) begin
            grant_data = data_req;
        end else if (data_req && inst_req) begin
            grant_data = last_inst_q;
        end else begin
            grant_data = data_req;
        end
    end

    // State register and latched fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_inst_q <= 1'b0;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            wstrb_q     <= 4'b0000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_inst_q <= last_inst_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state logic, including capture of the granted request.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_inst_d = last_inst_q;
        wr_d        = wr_q;
        size_d      = size_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d     = StReq;
                    owner_d     = grant_data;
                    last_inst_d = ~grant_data;
                    if (grant_data) begin
                        wr_d    = data_wr;
                        size_d  = data_size;
                        wstrb_d = data_wstrb;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else begin
                        wr_d    = inst_wr;
                        size_d  = inst_size;
                        wstrb_d = inst_wstrb;
                        addr_d  = inst_addr;
                        wdata_d = inst_wdata;
                    end
                end
            end
            StReq: begin
                if (mem_addr_ok) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_data_ok) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs. Memory request fields are gated to StReq so the bus reads zero
    // whenever no request is being presented.
    always_comb begin
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'b00;
        mem_wstrb    = 4'b0000;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;

        unique case (state_q)
            StIdle: begin
                // Stray mem_addr_ok / mem_data_ok are dropped here.
            end
            StReq: begin
                mem_req   = 1'b1;
                mem_wr    = wr_q;
                mem_size  = size_q;
                mem_wstrb = wstrb_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (owner_q) begin
                    data_addr_ok = mem_addr_ok;
                end else begin
                    inst_addr_ok = mem_addr_ok;
                end
            end
            StResp: begin
                if (owner_q) begin
                    data_data_ok = mem_data_ok;
                    data_rdata   = mem_rdata;
                end else begin
                    inst_data_ok = mem_data_ok;
                    inst_rdata   = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
